// File: rtl/gbr_pkg.sv
// Shared types and helpers for the genetic TSP route engine (distance, fitness, selection).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gbr_pkg;

    // Widths shared with the fitness and selection stages.
    localparam int DIST_W_DEF  = 12;
    localparam int COORD_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Unsigned add clamped to 2^w-1. Operands are carried in 32 bits so one
    // helper serves any distance width up to 31 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/comp_distance_lane.sv
// One distance lane: Manhattan length of a single tour leg added into a saturating accumulator.
// Latency: leg is combinational; the accumulator updates on the clock edge where en is high.
// Backpressure: none; clr (priority) zeroes the sum, en adds the current leg.
module comp_distance_lane
    import gbr_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int DIST_W  = DIST_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [COORD_W-1:0] xa,
    input  logic [COORD_W-1:0] ya,
    input  logic [COORD_W-1:0] xb,
    input  logic [COORD_W-1:0] yb,
    output logic [DIST_W-1:0]  acc
);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W:0]   leg;

    assign dx  = (xa >= xb) ? (xa - xb) : (xb - xa);
    assign dy  = (ya >= yb) ? (ya - yb) : (yb - ya);
    // One extra bit holds the largest possible leg without overflow.
    assign leg = {1'b0, dx} + {1'b0, dy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= DIST_W'(sat_add(32'(acc), 32'(leg), DIST_W));
        end
    end

endmodule

// File: rtl/comp_distance_pop_seq.sv
// Population tour-distance evaluator: LANES lanes walk one leg per cycle, batch by batch, and track the minimum.
// Latency: done pulses NB*(N_CITIES+1)+1 cycles after the accepted start.
// Backpressure: start is taken only in IDLE/DONE and ignored while busy; inputs are latched on acceptance.
module comp_distance_pop_seq
    import gbr_pkg::*;
#(
    parameter int POP_SIZE = 50,
    parameter int N_CITIES = 16,
    parameter int CITY_W   = 4,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int LANES    = 5,
    parameter int DIST_W   = DIST_W_DEF,
    localparam int IDX_W   = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [POP_SIZE*N_CITIES*CITY_W-1:0] pop,
    input  logic [N_CITIES*2*COORD_W-1:0]       coords,
    output logic                                busy,
    output logic                                done,
    output logic [POP_SIZE*DIST_W-1:0]          dist_out,
    output logic [DIST_W-1:0]                   best_dist,
    output logic [IDX_W-1:0]                    best_idx
);

    localparam int NB      = (POP_SIZE + LANES - 1) / LANES;
    localparam int B_W     = (NB > 1) ? $clog2(NB) : 1;
    localparam int K_W     = $clog2(N_CITIES);
    localparam int ROUTE_W = N_CITIES * CITY_W;

    state_e                              state;
    logic [POP_SIZE*N_CITIES*CITY_W-1:0] pop_q;
    logic [N_CITIES*2*COORD_W-1:0]       coords_q;
    logic [B_W-1:0]                      b_q;
    logic [K_W-1:0]                      k_q;

    logic                                start_acc;
    logic                                lane_clr;
    logic                                lane_en;
    logic [DIST_W-1:0]                   acc [LANES];

    logic [POP_SIZE*DIST_W-1:0]          dist_nxt;
    logic [DIST_W-1:0]                   bd_nxt;
    logic [IDX_W-1:0]                    bi_nxt;

    assign start_acc = start && ((state == IDLE) || (state == DONE));
    // Lanes are zeroed both when a run starts and while a batch is being committed,
    // so every batch begins its first leg from a clean accumulator.
    assign lane_clr  = start_acc || (state == COMMIT);
    assign lane_en   = (state == RUN);

    assign busy = (state == RUN) || (state == COMMIT);
    assign done = (state == DONE);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        int                 idx;
        int                 k_cur;
        int                 k_nxt;
        int                 ga;
        int                 gb;
        int                 ca;
        int                 cb;
        logic [COORD_W-1:0] xa;
        logic [COORD_W-1:0] ya;
        logic [COORD_W-1:0] xb;
        logic [COORD_W-1:0] yb;

        always_comb begin
            idx = int'(b_q) * LANES + j;
            // Lanes past the population end still compute, on individual 0; their result is dropped.
            if (idx >= POP_SIZE) begin
                idx = 0;
            end
            k_cur = int'(k_q);
            k_nxt = (k_cur == N_CITIES - 1) ? 0 : k_cur + 1;
            ga = int'(pop_q[idx*ROUTE_W + k_cur*CITY_W +: CITY_W]);
            gb = int'(pop_q[idx*ROUTE_W + k_nxt*CITY_W +: CITY_W]);
            // Out-of-range gene values fall back to city 0.
            ca = (ga >= N_CITIES) ? 0 : ga;
            cb = (gb >= N_CITIES) ? 0 : gb;
            xa = coords_q[ca*2*COORD_W +: COORD_W];
            ya = coords_q[ca*2*COORD_W + COORD_W +: COORD_W];
            xb = coords_q[cb*2*COORD_W +: COORD_W];
            yb = coords_q[cb*2*COORD_W + COORD_W +: COORD_W];
        end

        comp_distance_lane #(
            .COORD_W (COORD_W),
            .DIST_W  (DIST_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (lane_clr),
            .en    (lane_en),
            .xa    (xa),
            .ya    (ya),
            .xb    (xb),
            .yb    (yb),
            .acc   (acc[j])
        );
    end

    // Commit view of the current batch: walking lanes in ascending order with a
    // strict compare keeps the lowest index on ties, also across batches.
    always_comb begin
        dist_nxt = dist_out;
        bd_nxt   = best_dist;
        bi_nxt   = best_idx;
        for (int j = 0; j < LANES; j++) begin
            if (int'(b_q) * LANES + j < POP_SIZE) begin
                dist_nxt[(int'(b_q)*LANES + j)*DIST_W +: DIST_W] = acc[j];
                if (acc[j] < bd_nxt) begin
                    bd_nxt = acc[j];
                    bi_nxt = IDX_W'(int'(b_q) * LANES + j);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pop_q     <= '0;
            coords_q  <= '0;
            b_q       <= '0;
            k_q       <= '0;
            dist_out  <= '0;
            best_dist <= '1;
            best_idx  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pop_q     <= pop;
                        coords_q  <= coords;
                        b_q       <= '0;
                        k_q       <= '0;
                        best_dist <= '1;
                        best_idx  <= '0;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (k_q == K_W'(N_CITIES - 1)) begin
                        k_q   <= '0;
                        state <= COMMIT;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                COMMIT: begin
                    dist_out  <= dist_nxt;
                    best_dist <= bd_nxt;
                    best_idx  <= bi_nxt;
                    if (b_q == B_W'(NB - 1)) begin
                        state <= DONE;
                    end else begin
                        b_q   <= b_q + 1'b1;
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
